// File: rtl/tensor_core_instruction_sequencer.sv
// tensor_core_instruction_sequencer: program sequencer that fetches 16-bit instructions and issues them to tensor_core_controller
// Ports:
//   clock_in, reset_in                          rising-edge clock, asynchronous active-low reset
//   start_in                                    run the program from address 0 (honoured in IDLE/HALTED)
//   prog_write_enable_in/_address_in/_data_in   program memory write port (honoured in IDLE/HALTED)
//   core_done_in                                matmul completion pulse from the core
//   current_instruction, instruction_valid_out  issued word and its one-cycle strobe
//   pc_out, busy_out, halted_out, error_out     program counter and status
module tensor_core_instruction_sequencer #(
    parameter int         PROGRAM_DEPTH = 256,
    parameter int         ADDRESS_WIDTH = 8,
    parameter logic [3:0] MATMUL_OPCODE = 4'h3,
    parameter int         DONE_TIMEOUT  = 1023
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     start_in,
    input  logic                     prog_write_enable_in,
    input  logic [ADDRESS_WIDTH-1:0] prog_write_address_in,
    input  logic [15:0]              prog_write_data_in,
    input  logic                     core_done_in,
    output logic [15:0]              current_instruction,
    output logic                     instruction_valid_out,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic                     busy_out,
    output logic                     halted_out,
    output logic                     error_out
);
    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, HALTED} state_t;
    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]               loop_q, loop_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     advance;
    logic [15:0]              mem [PROGRAM_DEPTH];
    logic [15:0]              word_q;
    // Read data is captured only in FETCH so the word stays stable through DECODE and ISSUE.
    always_ff @(posedge clock_in) begin
        if (prog_write_enable_in && (state_q == IDLE || state_q == HALTED))
            mem[prog_write_address_in] <= prog_write_data_in;
        if (state_q == FETCH)
            word_q <= mem[pc_q];
    end
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            pc_q    <= '0;
            loop_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        advance = 1'b0;
        case (state_q)
            IDLE, HALTED: if (start_in) begin
                state_d = FETCH;
                pc_d    = '0;
                loop_d  = '0;
                err_d   = 1'b0;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (word_q[15:12] != 4'hF) state_d = ISSUE;
                else case (word_q[11:10])
                    2'b00: advance = 1'b1;
                    2'b01: state_d = HALTED;
                    2'b10: begin
                        loop_d  = word_q[7:0];
                        advance = 1'b1;
                    end
                    default: if (loop_q != 8'd0) begin
                        loop_d  = loop_q - 8'd1;
                        pc_d    = word_q[ADDRESS_WIDTH-1:0];
                        state_d = FETCH;
                    end else advance = 1'b1;
                endcase
            end
            ISSUE: if (word_q[15:12] == MATMUL_OPCODE) begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end else advance = 1'b1;
            // Done wins over a timeout landing in the same cycle.
            WAIT_DONE: if (core_done_in) advance = 1'b1;
            else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                state_d = HALTED;
                err_d   = 1'b1;
            end else cnt_d = cnt_q + CW'(1);
            default: state_d = IDLE;
        endcase
        // Stepping past the last word is a program error, not a wrap.
        if (advance) begin
            if (pc_q == ADDRESS_WIDTH'(PROGRAM_DEPTH - 1)) begin
                state_d = HALTED;
                err_d   = 1'b1;
            end else begin
                pc_d    = pc_q + ADDRESS_WIDTH'(1);
                state_d = FETCH;
            end
        end
    end
    always_comb begin
        current_instruction   = (state_q == ISSUE) ? word_q : 16'h0000;
        instruction_valid_out = state_q == ISSUE;
        busy_out              = state_q inside {FETCH, DECODE, ISSUE, WAIT_DONE};
        halted_out            = state_q == HALTED;
        pc_out                = pc_q;
        error_out             = err_q;
    end
endmodule

// File: tb/tb_tensor_core_instruction_sequencer.sv
// tb_tensor_core_instruction_sequencer: program-level model of the sequencer checked against the DUT every cycle
module tb_tensor_core_instruction_sequencer;
    localparam int DEPTH = 256;
    localparam int TO    = 1023;
    localparam int MAXT  = 4096;
    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        start_in = 1'b0;
    logic        prog_write_enable_in = 1'b0;
    logic [7:0]  prog_write_address_in = '0;
    logic [15:0] prog_write_data_in = '0;
    logic        core_done_in = 1'b0;
    logic [15:0] current_instruction;
    logic        instruction_valid_out;
    logic [7:0]  pc_out;
    logic        busy_out;
    logic        halted_out;
    logic        error_out;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] prog [DEPTH];
    logic [15:0] wq [$];
    int          dly [$];
    bit          e_v [MAXT];
    bit          e_b [MAXT];
    bit          e_h [MAXT];
    bit          e_e [MAXT];
    logic [15:0] e_w [MAXT];
    logic [7:0]  e_p [MAXT];
    bit          d_done [MAXT];
    bit          d_st [MAXT];
    bit          d_we [MAXT];
    int          obs_t [$];
    logic [15:0] obs_w [$];
    int          obs_h;

    tensor_core_instruction_sequencer dut (
        .clock_in(clock_in),
        .reset_in(reset_in),
        .start_in(start_in),
        .prog_write_enable_in(prog_write_enable_in),
        .prog_write_address_in(prog_write_address_in),
        .prog_write_data_in(prog_write_data_in),
        .core_done_in(core_done_in),
        .current_instruction(current_instruction),
        .instruction_valid_out(instruction_valid_out),
        .pc_out(pc_out),
        .busy_out(busy_out),
        .halted_out(halted_out),
        .error_out(error_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ot(input int i);
        return i < obs_t.size() ? obs_t[i] : -1;
    endfunction

    function automatic int ow(input int i);
        return i < obs_w.size() ? int'(obs_w[i]) : -1;
    endfunction

    function automatic void mark(input int t, input int pc);
        e_b[t] = 1'b1;
        e_p[t] = 8'(pc);
    endfunction

    // Interprets the program one instruction at a time, charging 3 cycles per issued
    // word, 2 per local control word and 1 extra per cycle spent waiting for done.
    task automatic build(input bit noise, output int len);
        int t = 0, pc = 0, lc = 0, h = -1, nxt = 0, d;
        bit err = 1'b0, adv;
        logic [15:0] w;
        for (int i = 0; i < MAXT; i++) begin
            e_v[i] = 0; e_b[i] = 0; e_h[i] = 0; e_e[i] = 0; e_w[i] = '0; e_p[i] = '0;
            d_done[i] = noise && ($urandom_range(0, 4) == 0);
            d_st[i] = 0; d_we[i] = 0;
        end
        while (h < 0) begin
            w = prog[pc];
            adv = 1'b1;
            mark(t, pc);
            mark(t + 1, pc);
            if (w[15:12] != 4'hF) begin
                mark(t + 2, pc);
                e_v[t + 2] = 1'b1;
                e_w[t + 2] = w;
                nxt = t + 3;
                if (w[15:12] == 4'h3) begin
                    d = dly.size() > 0 ? dly.pop_front() : int'($urandom_range(0, 12));
                    if (d < 0 || d >= TO) begin
                        for (int k = 0; k < TO; k++) begin mark(t + 3 + k, pc); d_done[t + 3 + k] = 0; end
                        h = t + 3 + TO;
                        err = 1'b1;
                        adv = 1'b0;
                    end else begin
                        for (int k = 0; k <= d; k++) begin mark(t + 3 + k, pc); d_done[t + 3 + k] = (k == d); end
                        nxt = t + 4 + d;
                    end
                end
            end else begin
                nxt = t + 2;
                case (w[11:10])
                    2'b01: begin h = t + 2; adv = 1'b0; end
                    2'b10: lc = int'(w[7:0]);
                    2'b11: if (lc != 0) begin lc--; pc = int'(w[7:0]); t = nxt; adv = 1'b0; end
                    default: ;
                endcase
            end
            if (adv) begin
                if (pc == DEPTH - 1) begin h = nxt; err = 1'b1; end
                else begin pc++; t = nxt; end
            end
            if (h < 0 && t > MAXT - TO - 16) h = t;
        end
        for (int i = 0; i < h; i++) begin
            d_st[i] = noise && ($urandom_range(0, 5) == 0);
            d_we[i] = noise && ($urandom_range(0, 3) == 0);
        end
        for (int i = h; i < h + 4; i++) begin
            e_h[i] = 1'b1;
            e_p[i] = 8'(pc);
            e_e[i] = err;
        end
        len = h + 4;
    endtask

    task automatic run(input bit noise);
        int len;
        build(noise, len);
        obs_t.delete();
        obs_w.delete();
        obs_h = -1;
        @(negedge clock_in);
        start_in = 1'b1;
        @(posedge clock_in);
        #1;
        for (int t = 0; t < len; t++) begin
            start_in = d_st[t];
            core_done_in = d_done[t];
            prog_write_enable_in = d_we[t];
            prog_write_address_in = 8'($urandom);
            prog_write_data_in = 16'($urandom);
            @(negedge clock_in);
            chk($sformatf("instr@%0d", t), 32'(current_instruction), 32'(e_w[t]));
            chk($sformatf("valid@%0d", t), 32'(instruction_valid_out), 32'(e_v[t]));
            chk($sformatf("busy@%0d", t), 32'(busy_out), 32'(e_b[t]));
            chk($sformatf("halted@%0d", t), 32'(halted_out), 32'(e_h[t]));
            chk($sformatf("error@%0d", t), 32'(error_out), 32'(e_e[t]));
            chk($sformatf("pc@%0d", t), 32'(pc_out), 32'(e_p[t]));
            if (instruction_valid_out) begin
                obs_t.push_back(t);
                obs_w.push_back(current_instruction);
            end
            if (halted_out && obs_h < 0) obs_h = t;
            @(posedge clock_in);
            #1;
        end
        start_in = 1'b0;
        core_done_in = 1'b0;
        prog_write_enable_in = 1'b0;
    endtask

    task automatic load(input int base);
        foreach (wq[i]) begin
            @(negedge clock_in);
            prog_write_enable_in = 1'b1;
            prog_write_address_in = 8'(base + i);
            prog_write_data_in = wq[i];
            prog[base + i] = wq[i];
        end
        @(negedge clock_in);
        prog_write_enable_in = 1'b0;
    endtask

    task automatic fill(input logic [15:0] w);
        wq = {};
        for (int i = 0; i < DEPTH; i++) wq.push_back(w);
        load(0);
    endtask

    function automatic logic [15:0] rnd_op();
        return ($urandom_range(0, 3) == 0) ? {4'h3, 12'($urandom)} : {4'($urandom_range(0, 14)), 12'($urandom)};
    endfunction

    task automatic gen();
        int segs;
        segs = $urandom_range(3, 7);
        wq = {};
        for (int s = 0; s < segs; s++) begin
            case ($urandom_range(0, 4))
                0, 1: wq.push_back(rnd_op());
                2: wq.push_back(16'hF000 | 16'($urandom_range(0, 1023)));
                3: wq.push_back(16'hFC00 | 16'($urandom_range(0, 255)));
                default: begin
                    int st;
                    st = wq.size() + 1;
                    wq.push_back(16'hF800 | 16'($urandom_range(0, 3) << 8) | 16'($urandom_range(0, 3)));
                    for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                        wq.push_back(($urandom_range(0, 3) == 0) ? (16'hF000 | 16'($urandom_range(0, 1023))) : rnd_op());
                    wq.push_back(16'hFC00 | 16'($urandom_range(0, 3) << 8) | 16'(st));
                end
            endcase
        end
        wq.push_back(16'hF400 | 16'($urandom_range(0, 1023)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock_in);
        chk("rst instr", 32'(current_instruction), 32'h0);
        chk("rst valid", 32'(instruction_valid_out), 32'h0);
        chk("rst busy", 32'(busy_out), 32'h0);
        chk("rst halted", 32'(halted_out), 32'h0);
        chk("rst error", 32'(error_out), 32'h0);
        chk("rst pc", 32'(pc_out), 32'h0);
        @(negedge clock_in);
        reset_in = 1'b1;
        fill(16'hF400);

        wq = {16'h1005, 16'h2010, 16'hF400};
        load(0);
        run(0);
        chk("t1 issues", obs_t.size(), 2);
        chk("t1 first time", ot(0), 2);
        chk("t1 first word", ow(0), 32'h1005);
        chk("t1 second time", ot(1), 5);
        chk("t1 second word", ow(1), 32'h2010);
        chk("t1 halt time", obs_h, 8);
        chk("t1 halted", 32'(halted_out), 1);
        chk("t1 error", 32'(error_out), 0);
        chk("t1 pc", 32'(pc_out), 2);

        wq = {16'h3000, 16'h1001, 16'hF400};
        load(0);
        dly = {6};
        run(0);
        chk("t2 issues", obs_t.size(), 2);
        chk("t2 matmul time", ot(0), 2);
        chk("t2 after done time", ot(1), 12);
        chk("t2 after done word", ow(1), 32'h1001);
        chk("t2 halt time", obs_h, 15);

        wq = {16'hF802, 16'h1111, 16'hFC01, 16'hF400};
        load(0);
        run(0);
        chk("t3 issues", obs_t.size(), 3);
        chk("t3 body word", ow(2), 32'h1111);
        chk("t3 third time", ot(2), 14);
        chk("t3 halt time", obs_h, 19);

        wq = {16'h3000};
        load(0);
        dly = {-1};
        run(0);
        chk("t4 halt time", obs_h, 3 + TO);
        chk("t4 error", 32'(error_out), 1);
        chk("t4 pc", 32'(pc_out), 0);

        fill(16'hF000);
        run(0);
        chk("t5 issues", obs_t.size(), 0);
        chk("t5 halt time", obs_h, 2 * DEPTH);
        chk("t5 pc", 32'(pc_out), DEPTH - 1);
        chk("t5 error", 32'(error_out), 1);

        wq = {16'h1005, 16'h3000, 16'h1001, 16'hF400};
        load(0);
        @(negedge clock_in);
        start_in = 1'b1;
        @(posedge clock_in);
        #1;
        start_in = 1'b0;
        repeat (6) @(posedge clock_in);
        #1;
        prog_write_enable_in = 1'b1;
        prog_write_address_in = 8'd2;
        prog_write_data_in = 16'h7777;
        @(posedge clock_in);
        #1;
        prog_write_enable_in = 1'b0;
        @(negedge clock_in);
        chk("t6 waiting busy", 32'(busy_out), 1);
        chk("t6 waiting pc", 32'(pc_out), 1);
        reset_in = 1'b0;
        #1;
        chk("t6 async instr", 32'(current_instruction), 0);
        chk("t6 async valid", 32'(instruction_valid_out), 0);
        chk("t6 async busy", 32'(busy_out), 0);
        chk("t6 async halted", 32'(halted_out), 0);
        chk("t6 async error", 32'(error_out), 0);
        chk("t6 async pc", 32'(pc_out), 0);
        repeat (2) @(negedge clock_in);
        reset_in = 1'b1;
        dly = {4};
        run(0);
        chk("t6 replay issues", obs_t.size(), 3);
        chk("t6 replay word", ow(2), 32'h1001);
        chk("t6 replay time", ot(2), 13);

        for (int r = 0; r < 10; r++) begin
            gen();
            load(0);
            run(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tensor_core_instruction_sequencer.md
Name: tensor_core_instruction_sequencer

Overview:
Program sequencer in front of tensor_core_controller. It holds a local program memory of 16-bit tensor-core instructions, steps a program counter, and presents one instruction per issue on current_instruction. It stalls on matrix-multiply instructions until the core signals completion. It executes a small set of sequencer-local control instructions (NOP, HALT, LOOP_SET, LOOP_BACK) without forwarding them.

Parameters:
PROGRAM_DEPTH, 256, number of 16-bit words in program memory (power of two)
ADDRESS_WIDTH, 8, log2(PROGRAM_DEPTH)
MATMUL_OPCODE, 4'h3, value of instruction[15:12] that requires waiting for core_done_in
DONE_TIMEOUT, 1023, maximum cycles spent in WAIT_DONE before an error halt

Ports:
clock_in  input  1  single system clock, rising edge
reset_in  input  1  asynchronous, active-low reset
start_in  input  1  one-cycle pulse; starts execution at address 0 when IDLE or HALTED
prog_write_enable_in  input  1  program memory write strobe
prog_write_address_in  input  ADDRESS_WIDTH  program write address
prog_write_data_in  input  16  program write data
core_done_in  input  1  one-cycle pulse from the core when a matmul completes
current_instruction  output  16  instruction to tensor_core_controller; 16'h0000 when not issuing
instruction_valid_out  output  1  high for exactly the one cycle an instruction is issued
pc_out  output  ADDRESS_WIDTH  current program counter
busy_out  output  1  high in FETCH, DECODE, ISSUE, WAIT_DONE
halted_out  output  1  high in HALTED
error_out  output  1  sticky; set on timeout or fall-off-end; cleared by start_in or reset

Behaviour:
- Reset (reset_in=0, async): state=IDLE; pc, loop_count, timeout counter = 0; current_instruction=16'h0000; instruction_valid_out, busy_out, halted_out, error_out = 0. Program memory contents are not reset.
- Program memory: synchronous write, synchronous read (1-cycle). Writes are accepted only in IDLE or HALTED and ignored otherwise.
- States and transitions:
  - IDLE: on start_in -> FETCH with pc=0, error_out cleared.
  - FETCH: drive read address = pc -> DECODE.
  - DECODE: evaluate the read word w.
    - If w[15:12]!=4'hF -> ISSUE.
    - Otherwise, by w[11:10]:
      - 00 NOP: advance.
      - 01 HALT -> HALTED.
      - 10 LOOP_SET: loop_count <= w[7:0]; advance.
      - 11 LOOP_BACK: if loop_count!=0 then loop_count--, pc <= w[ADDRESS_WIDTH-1:0], -> FETCH; else advance.
  - advance: if pc==PROGRAM_DEPTH-1 -> HALTED with error_out=1; else pc+1 -> FETCH.
  - ISSUE: current_instruction=w, instruction_valid_out=1 for this cycle only. If w[15:12]==MATMUL_OPCODE -> WAIT_DONE with timeout counter cleared; else advance.
  - WAIT_DONE: current_instruction=0. On core_done_in, advance. Otherwise the counter increments; at DONE_TIMEOUT cycles -> HALTED with error_out=1.
  - HALTED: on start_in -> FETCH with pc=0, loop_count=0, error_out cleared.
- Latency: start_in sampled at edge N gives the first issue at edge N+3 (FETCH, DECODE, ISSUE). Non-matmul throughput is one issue per 3 cycles.
- Loop semantics: LOOP_SET k followed by a body ending in LOOP_BACK runs the body k+1 times. There is a single loop level; LOOP_SET inside a body overwrites the count.
- core_done_in outside WAIT_DONE is ignored. start_in while busy is ignored.
- A write to the address currently being fetched cannot occur, because writes are blocked while busy.
- Reset asserted mid-WAIT_DONE or mid-issue returns to IDLE immediately. current_instruction and valid drop asynchronously.

Test Plan:
- Load [0x1005, 0x2010, 0xF400], pulse start_in -> valid pulses carry 0x1005 then 0x2010, spaced 3 cycles apart; first issue 3 cycles after start; then halted_out=1, error_out=0, pc_out=2.
- Load [0x3000, 0x1001, 0xF400], core_done_in pulsed 7 cycles after the 0x3000 issue -> 0x1001 is issued only after the done pulse; no issue occurs during the wait.
- Load [0xF802, 0x1111, 0xFC01, 0xF400] -> 0x1111 is issued exactly 3 times, then HALTED.
- Load [0x3000] with core_done_in held 0 -> HALTED and error_out=1 after DONE_TIMEOUT cycles in WAIT_DONE.
- Fill all PROGRAM_DEPTH words with 0xF000 (NOP) -> HALTED at pc_out=PROGRAM_DEPTH-1 with error_out=1 and no valid pulses.
- Assert reset_in low during WAIT_DONE -> outputs are 0 immediately. A prog write while busy is ignored, verified by reading back via rerun. start_in after reset replays the unchanged program.
